regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, deferred-write queue entries (2..8, power of two).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: wbValid  input  1  pipeline writeback request; never back-pressured.
REQ-005 SHALL have port: wbRd  input  REG_FILE_ADDR_LEN  writeback destination.
REQ-006 SHALL have port: wbData  input  WORD_LEN  writeback value.
REQ-007 SHALL have port: mcValid  input  1  multicycle-unit result request.
REQ-008 SHALL have port: mcRd  input  REG_FILE_ADDR_LEN  multicycle destination.
REQ-009 SHALL have port: mcData  input  WORD_LEN  multicycle value.
REQ-010 SHALL have port: mcReady  output  1  multicycle result accepted this cycle when high with mcValid.
REQ-011 SHALL have port: regWrite  output  1  register-file write enable.
REQ-012 SHALL have port: Rd  output  REG_FILE_ADDR_LEN  register-file write address.
REQ-013 SHALL have port: writeData  output  WORD_LEN  register-file write data.
REQ-014 SHALL have port: pendingMask  output  REG_FILE_SIZE  bit i high while a live queued write targets register i.
REQ-015 SHALL have port: queueCount  output  4  occupied queue slots, live or squashed.
REQ-016 SHALL have port: deferCount  output  16  deferred-write statistic (see Configuration).

Function
REQ-017 SHALL select the write source combinationally each cycle by priority: wbValid, then queue head, then bypassed mc request.
REQ-018 SHALL assert mcReady = (queueCount < DEPTH), independent of mcValid.
REQ-019 SHALL, for mcValid&mcReady with no wbValid and an empty queue, drive mc directly to the write port (zero latency, no enqueue).
REQ-020 SHALL otherwise enqueue an accepted mc request at tail on the clock edge; queued writes reach the port in FIFO order.
REQ-021 SHALL pop the queue head on any cycle without wbValid; a live head drives regWrite=1, a squashed head is popped with regWrite=0.
REQ-022 SHALL, on wbValid, clear the live bit of every queued entry whose Rd equals wbRd (WAW squash; writeback is younger).
REQ-023 SHALL discard an mc request accepted in the same cycle as wbValid with mcRd==wbRd (consumed, not enqueued, no write).
REQ-024 SHALL treat requests to register 0 as accepted and discarded: regWrite=0 for wb, no enqueue for mc, no pendingMask bit.
REQ-025 SHALL support simultaneous push and pop in one cycle; queueCount unchanged in that case.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH.
REQ-027 SHALL derive pendingMask combinationally from live queue entries only.
REQ-028 SHALL drive Rd and writeData to zero whenever regWrite=0.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear queue, pointers, live bits and counters; regWrite=0, Rd=0, writeData=0, pendingMask=0, queueCount=0, deferCount=0, mcReady=0.
REQ-030 SHALL, on reset assertion mid-operation, drop all queued writes without writing them.
REQ-031 SHALL accept requests on the first rising edge after rst returns to 1.

Configuration
REQ-032 SHALL, with ARB_STATS_EN defined, increment deferCount (saturating at 16'hFFFF) on each mc request enqueued rather than bypassed.
REQ-033 SHALL, without ARB_STATS_EN, tie deferCount to 0 and synthesise no counter.

Verification
REQ-034 SHALL cover: mcValid=1, mcRd=5, mcData=32'hA, idle queue -> same cycle regWrite=1, Rd=5, writeData=32'hA, queueCount=0.
REQ-035 SHALL cover: wbValid and mcValid together, wbRd=3, mcRd=7 -> wb written; next cycle Rd=7 written; deferCount=1 with ARB_STATS_EN.
REQ-036 SHALL cover: DEPTH=2, wbValid held 3 cycles with mc results each cycle -> mcReady low in cycle 3, queueCount=2, queued writes drained in order after wb drops.
REQ-037 SHALL cover: queued mc write to Rd=9 then wbValid wbRd=9 -> pendingMask[9] clears, squashed head popped with regWrite=0, register 9 holds wb value.
REQ-038 SHALL cover: mcRd=0 and wbRd=0 requests -> regWrite=0, queueCount=0.
REQ-039 SHALL cover: rst=0 with queueCount=2 mid-drain -> all outputs 0 immediately, no further writes after release.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the register-file write arbitration signals.
//   Requests: wbValid/wbRd/wbData (pipeline writeback, never stalled),
//             mcValid/mcRd/mcData with mcReady handshake (multicycle unit).
//   Results:  regWrite/Rd/writeData (register-file write port),
//             pendingMask, queueCount, deferCount (status).
//   Modports: slave  - the arbiter (consumes requests, drives results)
//             master - the requester side / environment.
interface regfile_write_arbiter_if #(
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int WORD_LEN          = 32,
  parameter int REG_FILE_SIZE     = 32
);
  logic                         wbValid;
  logic [REG_FILE_ADDR_LEN-1:0] wbRd;
  logic [WORD_LEN-1:0]          wbData;
  logic                         mcValid;
  logic [REG_FILE_ADDR_LEN-1:0] mcRd;
  logic [WORD_LEN-1:0]          mcData;
  logic                         mcReady;
  logic                         regWrite;
  logic [REG_FILE_ADDR_LEN-1:0] Rd;
  logic [WORD_LEN-1:0]          writeData;
  logic [REG_FILE_SIZE-1:0]     pendingMask;
  logic [3:0]                   queueCount;
  logic [15:0]                  deferCount;

  modport slave (
    input  wbValid, wbRd, wbData, mcValid, mcRd, mcData,
    output mcReady, regWrite, Rd, writeData, pendingMask, queueCount, deferCount
  );

  modport master (
    output wbValid, wbRd, wbData, mcValid, mcRd, mcData,
    input  mcReady, regWrite, Rd, writeData, pendingMask, queueCount, deferCount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates the single register-file write port between the pipeline
//   writeback (highest priority, never stalled) and a multicycle unit.
//   Multicycle results that cannot be written immediately are held in a
//   DEPTH-entry FIFO and drained on cycles without a writeback. A younger
//   writeback squashes queued writes to the same register (WAW).
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - regfile_write_arbiter_if.slave (requests in, write port and
//            status out)
//   Optional feature: define ARB_STATS_EN to count deferred (enqueued)
//   multicycle writes in deferCount, saturating at 16'hFFFF. Without it
//   deferCount is tied to zero.
module regfile_write_arbiter #(
  parameter int DEPTH             = 2,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int WORD_LEN          = 32,
  parameter int REG_FILE_SIZE     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_FILE_ADDR_LEN-1:0] q_rd   [DEPTH];
  logic [WORD_LEN-1:0]          q_data [DEPTH];
  logic [DEPTH-1:0]             q_live;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;

  logic                         empty;
  logic                         mc_ready;
  logic                         mc_acc;
  logic                         mc_drop;
  logic                         bypass;
  logic                         push;
  logic                         pop;
  logic                         wr_en;
  logic [REG_FILE_ADDR_LEN-1:0] wr_rd;
  logic [WORD_LEN-1:0]          wr_data;
  logic [REG_FILE_SIZE-1:0]     pend;

  always_comb begin
    empty    = (count == '0);
    // Outputs are gated by rst so everything reads zero while held in reset.
    mc_ready = rst && (count < CNT_W'(DEPTH));
    mc_acc   = bus.mcValid && mc_ready;
    // Register 0 writes and mc writes shadowed by a same-cycle writeback to
    // the same register are consumed without ever reaching the port.
    mc_drop  = (bus.mcRd == '0) || (bus.wbValid && (bus.mcRd == bus.wbRd));
    bypass   = mc_acc && !bus.wbValid && empty && !mc_drop;
    push     = mc_acc && !mc_drop && !bypass;
    pop      = rst && !bus.wbValid && !empty;

    wr_en   = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    if (rst) begin
      if (bus.wbValid) begin
        if (bus.wbRd != '0) begin
          wr_en   = 1'b1;
          wr_rd   = bus.wbRd;
          wr_data = bus.wbData;
        end
      end else if (!empty) begin
        // A squashed head is still popped, just without a write.
        if (q_live[head]) begin
          wr_en   = 1'b1;
          wr_rd   = q_rd[head];
          wr_data = q_data[head];
        end
      end else if (bypass) begin
        wr_en   = 1'b1;
        wr_rd   = bus.mcRd;
        wr_data = bus.mcData;
      end
    end
  end

  // Live bits are cleared on pop, so free slots never contribute here.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) pend[q_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (bus.wbValid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == bus.wbRd) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      // A push never lands on the slot being popped: push into a full queue
      // is blocked by mcReady, and an empty queue has nothing to pop.
      if (push) begin
        q_rd[tail]   <= bus.mcRd;
        q_data[tail] <= bus.mcData;
        q_live[tail] <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] defer_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      defer_cnt <= '0;
    end else if (push) begin
      defer_cnt <= sat_inc(defer_cnt);
    end
  end

  assign bus.deferCount = rst ? defer_cnt : 16'd0;
`else
  assign bus.deferCount = 16'd0;
`endif

  assign bus.mcReady     = mc_ready;
  assign bus.regWrite    = wr_en;
  assign bus.Rd          = wr_rd;
  assign bus.writeData   = wr_data;
  assign bus.pendingMask = rst ? pend : '0;
  assign bus.queueCount  = rst ? 4'(count) : 4'd0;

endmodule
